// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial pattern-detection run controller.
package seq_ctrl_pkg;

   localparam int PAT_W_DEF = 5;
   localparam int CNT_W_DEF = 8;
   localparam int TMO_W_DEF = 16;

   // One-hot run state encoding
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_ARM  = 4'b0010,
      ST_RUN  = 4'b0100,
      ST_DONE = 4'b1000
   } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Shift-register pattern matcher: holds the window of recent valid bits and
// the fill count; hit compares the window that would result from shifting
// din now against the pattern (mask bit 0 = don't care).
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   input  logic [PAT_W-1:0] mask,
   output logic             full,
   output logic             hit
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

   logic [PAT_W-1:0] shreg_q;
   logic [FW-1:0]    fill_q;
   logic [PAT_W-1:0] window_w;

   assign window_w = {shreg_q[PAT_W-2:0], din};
   assign full     = (fill_q == FILL_MAX);
   // The bit arriving now completes the window once PAT_W-1 bits are held
   assign hit      = (fill_q >= (FILL_MAX - 1'b1)) &&
                     (((window_w ^ pattern) & mask) == '0);

   // Window and fill count; never cleared on a match so matches may overlap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q <= '0;
         fill_q  <= '0;
      end else if (clr) begin
         shreg_q <= '0;
         fill_q  <= '0;
      end else if (shift) begin
         shreg_q <= window_w;
         if (!full) fill_q <= fill_q + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: latches the run
// configuration on start, counts overlapping matches and finishes on target,
// timeout or abort.
// Build option SEQ_CTRL_MASK_EN adds the cfg_mask don't-care input.
//
// state   | meaning
// IDLE    | waiting for start; match_cnt/tmo hold last run's result
// ARM     | filling the shift register with the first PAT_W valid bits
// RUN     | window full, every valid bit compared
// DONE    | one-cycle completion, done asserted
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int TMO_W = TMO_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_vld,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [TMO_W-1:0] cfg_timeout,
`ifdef SEQ_CTRL_MASK_EN
   input  logic [PAT_W-1:0] cfg_mask,
`endif
   output logic             busy,
   output logic             done,
   output logic             tmo,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_cnt
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] mask_w;
   logic [CNT_W-1:0] tgt_q;
   logic [TMO_W-1:0] tlim_q;
   logic [TMO_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc_w;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tmo_q, tmo_d;
   logic             pulse_q, pulse_d;
   logic             latch_w, shift_w, full_w, hit_w, match_w;

`ifdef SEQ_CTRL_MASK_EN
   logic [PAT_W-1:0] mask_q;

   // Mask is part of the run configuration
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         mask_q <= '0;
      else if (latch_w) mask_q <= cfg_mask;
   end
   assign mask_w = mask_q;
`else
   assign mask_w = '1;
`endif

   seq_match_core #(.PAT_W(PAT_W)) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (latch_w),
      .shift   (shift_w),
      .din     (din),
      .pattern (pat_q),
      .mask    (mask_w),
      .full    (full_w),
      .hit     (hit_w)
   );

   assign cnt_inc_w = cnt_q + 1'b1;
   assign match_w   = shift_w && hit_w;

   // Run configuration, frozen for the whole run
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q  <= '0;
         tgt_q  <= '0;
         tlim_q <= '0;
      end else if (latch_w) begin
         pat_q  <= cfg_pattern;
         tgt_q  <= cfg_target;
         tlim_q <= cfg_timeout;
      end
   end

   // Next state, counters and registered outputs
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pulse_d = 1'b0;
      latch_w = 1'b0;
      shift_w = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               latch_w = 1'b1;
               timer_d = '0;
               cnt_d   = '0;
               tmo_d   = 1'b0;
               if (cfg_target == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ARM;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_ARM, ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               shift_w = din_vld;
               timer_d = timer_q + 1'b1;
               if (match_w) begin
                  pulse_d = 1'b1;
                  cnt_d   = cnt_inc_w;
               end
               // A final match takes precedence over a simultaneous timeout
               if (match_w && (cnt_inc_w == tgt_q)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if ((tlim_q != '0) && (timer_q == tlim_q - 1'b1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  tmo_d   = 1'b1;
               end else begin
                  busy_d = 1'b1;
                  if (state_q == ST_ARM && full_w) state_d = ST_RUN;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pulse_q <= pulse_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign tmo         = tmo_q;
   assign match_pulse = pulse_q;
   assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: behavioural run model checked every cycle, plus
// literal expectations per directed scenario.
module tb_seq_detect_ctrl;

   localparam int PAT_W = 5;
   localparam int CNT_W = 8;
   localparam int TMO_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             din = 1'b0;
   logic             din_vld = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [CNT_W-1:0] cfg_target = '0;
   logic [TMO_W-1:0] cfg_timeout = '0;
   logic             busy, done, tmo, match_pulse;
   logic [CNT_W-1:0] match_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_vld     (din_vld),
      .start       (start),
      .abort       (abort),
      .cfg_pattern (cfg_pattern),
      .cfg_target  (cfg_target),
      .cfg_timeout (cfg_timeout),
      .busy        (busy),
      .done        (done),
      .tmo         (tmo),
      .match_pulse (match_pulse),
      .match_cnt   (match_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cyc = 0;
   bit          m_run, m_donep, m_tmo, e_pulse, e_done;
   int          m_cnt, m_tgt, m_lim, elapsed, nbits;
   logic [31:0] hist, m_pat;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run = 0; m_donep = 0; m_tmo = 0; e_pulse = 0; e_done = 0;
         m_cnt = 0; elapsed = 0; nbits = 0; hist = 0;
      end else begin
         cyc++;
         e_pulse = 0;
         e_done  = 0;
         if (m_donep) begin
            m_donep = 0;
         end else if (!m_run) begin
            if (start && !abort) begin
               m_pat = 32'(cfg_pattern); m_tgt = int'(cfg_target); m_lim = int'(cfg_timeout);
               hist = 0; nbits = 0; elapsed = 0; m_cnt = 0; m_tmo = 0;
               if (m_tgt == 0) begin m_donep = 1; e_done = 1; end
               else m_run = 1;
            end
         end else if (abort) begin
            m_run = 0;
         end else begin
            bit hit;
            hit = 0;
            elapsed++;
            if (din_vld) begin
               hist = {hist[30:0], din};
               nbits++;
               hit = (nbits >= PAT_W) && ((hist & 32'h1F) == m_pat);
            end
            if (hit) begin e_pulse = 1; m_cnt++; end
            if (hit && m_cnt == m_tgt) begin
               m_run = 0; m_donep = 1; e_done = 1;
            end else if (m_lim != 0 && elapsed == m_lim) begin
               m_run = 0; m_donep = 1; e_done = 1; m_tmo = 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare + scenario statistics ----------------
   int pulse_n, done_n, busy_n, first_off, last_off, done_off, base_cyc;

   always @(negedge clk) begin
      if (rst) begin
         chk("busy",        32'(busy),        32'(m_run));
         chk("done",        32'(done),        32'(e_done));
         chk("tmo",         32'(tmo),         32'(m_tmo));
         chk("match_pulse", 32'(match_pulse), 32'(e_pulse));
         chk("match_cnt",   32'(match_cnt),   32'(m_cnt));
         if (match_pulse) begin
            if (pulse_n == 0) first_off = cyc - base_cyc;
            last_off = cyc - base_cyc;
            pulse_n++;
         end
         if (done) begin done_n++; done_off = cyc - base_cyc; end
         if (busy) busy_n++;
      end
   end

   task automatic clr_stats();
      pulse_n = 0; done_n = 0; busy_n = 0;
      first_off = -1; last_off = -1; done_off = -1;
   endtask

   // start is sampled on the next posedge; base_cyc is that edge's index
   task automatic do_start(input logic [PAT_W-1:0] p, input int t, input int lim);
      clr_stats();
      cfg_pattern = p;
      cfg_target  = CNT_W'(t);
      cfg_timeout = TMO_W'(lim);
      start = 1'b1;
      base_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      cfg_pattern = ~p;
      cfg_target  = 8'd1;
      cfg_timeout = 16'd2;
   endtask

   task automatic step(input logic d, input logic v);
      din = d;
      din_vld = v;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   logic [7:0] s1;
   logic [4:0] s5;

   initial begin
      clr_stats();
      base_cyc = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(match_cnt), 0);
      rst = 1'b1;
      idle(2);

      // 1: overlapping matches, target 2, no timeout
      s1 = 8'b10010010;
      do_start(5'b10010, 2, 0);
      for (int i = 7; i >= 0; i--) begin
         if (i == 4) begin start = 1'b1; end
         step(s1[i], 1'b1);
         start = 1'b0;
      end
      idle(3);
      chk("t1_pulses", 32'(pulse_n), 2);
      chk("t1_first_off", 32'(first_off), 5);
      chk("t1_last_off", 32'(last_off), 8);
      chk("t1_done_off", 32'(done_off), 8);
      chk("t1_cnt", 32'(match_cnt), 2);
      chk("t1_tmo", 32'(tmo), 0);

      // 2: timeout with constant zero stream
      do_start(5'b10010, 3, 20);
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1);
      chk("t2_busy_cycles", 32'(busy_n), 20);
      chk("t2_done", 32'(done_n), 1);
      chk("t2_tmo", 32'(tmo), 1);
      chk("t2_cnt", 32'(match_cnt), 0);

      // 3: zero target completes without busy
      do_start(5'b10010, 0, 0);
      idle(3);
      chk("t3_busy", 32'(busy_n), 0);
      chk("t3_done", 32'(done_n), 1);
      chk("t3_cnt", 32'(match_cnt), 0);
      chk("t3_tmo", 32'(tmo), 0);

      // 4: valid toggling; invalid cycles carry inverted data
      s5 = 5'b10010;
      do_start(5'b10010, 2, 0);
      for (int i = 4; i >= 0; i--) begin
         step(s5[i], 1'b1);
         step(~s5[i], 1'b0);
      end
      idle(2);
      chk("t4_pulses", 32'(pulse_n), 1);
      chk("t4_pulse_off", 32'(first_off), 9);
      chk("t4_cnt", 32'(match_cnt), 1);
      abort = 1'b1; step(1'b0, 1'b0); abort = 1'b0;
      idle(1);

      // 5: abort after one match keeps the partial count
      do_start(5'b10010, 4, 0);
      for (int i = 4; i >= 0; i--) step(s5[i], 1'b1);
      step(1'b0, 1'b1);
      abort = 1'b1; step(1'b0, 1'b0); abort = 1'b0;
      chk("t5_busy_after_abort", 32'(busy), 0);
      idle(2);
      chk("t5_done", 32'(done_n), 0);
      chk("t5_cnt", 32'(match_cnt), 1);
      chk("t5_tmo", 32'(tmo), 0);
      abort = 1'b1; start = 1'b1; step(1'b0, 1'b0); abort = 1'b0; start = 1'b0;
      chk("t5_start_with_abort", 32'(busy), 0);

      // 6: final match on the timeout cycle
      do_start(5'b10010, 1, 5);
      chk("t6_cnt_cleared", 32'(match_cnt), 0);
      for (int i = 4; i >= 0; i--) step(s5[i], 1'b1);
      idle(2);
      chk("t6_done", 32'(done_n), 1);
      chk("t6_tmo", 32'(tmo), 0);
      chk("t6_cnt", 32'(match_cnt), 1);

      // 7: asynchronous reset mid-run
      do_start(5'b10010, 3, 0);
      for (int i = 4; i >= 0; i--) step(s5[i], 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("t7_busy", 32'(busy), 0);
      chk("t7_cnt", 32'(match_cnt), 0);
      chk("t7_pulse", 32'(match_pulse), 0);
      chk("t7_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b1;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
